cic_pdm_multi: RTL and testbench
================================

// Module: cic_pdm_multi
// PURPOSE
//  Multi-channel PDM-to-PCM decimator: CIC of parametrised order and runtime-selectable decimation, then saturating scale and per-channel first-order DC-blocking HPF.
//  Sits between the PDM microphone front end and the PCM FIFO/I2S path.
//  Adds over the single-channel block: N channels, selectable order, saturation instead of wrap, and a valid/ready output with overrun flag.
// PARAMETERS
//  NUM_CH     2    PDM channels processed in lock-step
//  ORDER      3    CIC integrator/comb stage count (1..5)
//  MAX_DECIM  64   largest decimation ratio; CNT_W = $clog2(MAX_DECIM)
//  OUT_W      16   PCM sample width per channel
//  ACC_W      ORDER*CNT_W+2   (localparam) CIC accumulator width, two's complement
// PORTS
//  clk        in   1              PDM bit clock; single clock domain
//  rst        in   1              synchronous, active-high reset
//  pdm_in     in   NUM_CH         1 PDM bit per channel per clk; 1 -> +1, 0 -> -1
//  decim_m1   in   CNT_W          decimation ratio minus 1 (R = decim_m1+1)
//  scale_shift in  3              arithmetic right shift applied to CIC output
//  hpf_en     in   1              0 = HPF bypassed
//  hpf_alpha  in   8              HPF pole, y[n-1] weight = alpha/256
//  pcm_out    out  NUM_CH*OUT_W   channel c in bits [c*OUT_W +: OUT_W], signed
//  pcm_valid  out  1              sample set available
//  pcm_ready  in   1              consumer accepts when valid&ready
//  overrun    out  1              sticky: a sample set was dropped
//  overrun_clr in  1              clears overrun
// BEHAVIOUR
//  Reset: all integrators, combs, delay regs, HPF state, counter = 0; pcm_out=0, pcm_valid=0, overrun=0. Reset mid-frame discards the partial frame.
//  Integrators: every clk, i1 += pdm, ik += i(k-1); ACC_W modular (wrap intended).
//  Counter: counts 0..R-1; tick when count==R-1. decim_m1/scale_shift/hpf_* sampled only at tick; mid-frame changes take effect on the next frame.
//  Comb pipeline: stage k registered at tick+k (k=1..ORDER), c_k = c_(k-1) - c_(k-1)_delay, modular.
//  Scale: s = c_ORDER >>> scale_shift, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  HPF (hpf_en=1): y = sat( s - x_prev + ((alpha*y_prev) >>> 8) ), intermediate width OUT_W+10; x_prev<=s, y_prev<=y. With hpf_en=0, y=s and HPF state is held.
//  Latency: new pcm_out registered and pcm_valid=1 at tick+ORDER+1.
//  Handshake: pcm_out stable while pcm_valid & !pcm_ready; pcm_valid drops the cycle after acceptance unless a new set arrives.
//  New set arriving while pcm_valid & !pcm_ready: new set overwrites pcm_out, pcm_valid stays 1, overrun<=1. Arrival in the same cycle as acceptance is not an overrun.
//  overrun_clr coincident with a new overrun event: set wins.
//  First ORDER output frames after reset or a change of R are transient; no masking in RTL.
// STRUCTURE
//  Package cic_pdm_pkg: OUT_W default, sat() function, HPF shift constant (8), ACC_W formula.
//  Sub-module cic_pdm_chan (integrators, comb pipeline, scale/sat, HPF for one channel), instantiated NUM_CH times by generate.
//  Top holds the shared counter/tick, the registered control sample, the output register and the handshake/overrun logic.
// TESTING
//  1. ORDER=3, R=64, all-ones pdm, shift=4, hpf_en=0 -> steady pcm = +16384 on all channels, one valid per 64 clk.
//  2. Same as 1 with all-zeros pdm -> -16384. Shift=3 with all-ones -> saturates to 32767, not wrapped.
//  3. Alternating 1010 pdm, R=64 -> steady 0. ch0=ones, ch1=zeros -> ch0=+16384, ch1=-16384 in the same beat.
//  4. hpf_en=1, alpha=240, all-ones -> first output large positive, then decays monotonically toward 0 (|y|<64 within 100 frames).
//  5. Hold pcm_ready=0 across two ticks -> pcm_out=second set, overrun=1. Then overrun_clr -> overrun=0. Ready asserted on the arrival cycle -> no overrun.
//  6. Change decim_m1 63->31 mid-frame -> current frame still 64 clk, next valids every 32 clk. rst mid-frame -> pcm_valid=0 next cycle, all state cleared.

Source files
------------

// File: rtl/cic_pdm_pkg.sv
// Shared constants, control-sample struct and saturation helper for the PDM-to-PCM CIC decimator.
package cic_pdm_pkg;

  localparam int OUT_W_DEF = 16;
  localparam int HPF_SHIFT = 8;
  localparam int HPF_GUARD = 10;

  typedef struct packed {
    logic [2:0] shift;
    logic       hpf_en;
    logic [7:0] alpha;
  } ctrl_t;

  function automatic int acc_w(input int order, input int cnt_w);
    return order * cnt_w + 2;
  endfunction

  // Clamp a wide signed value into the w-bit two's complement range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/cic_pdm_chan.sv
// One PDM channel: integrator chain, tick-strobed comb pipeline, scale/saturate and DC-blocking HPF.
module cic_pdm_chan
  import cic_pdm_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int ACC_W = 20,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pdm,
  input  logic [ORDER:0]          vld_pipe,
  input  ctrl_t                   ctrl,
  output logic signed [OUT_W-1:0] y
);

  localparam int HW = OUT_W + HPF_GUARD;

  logic signed [ACC_W-1:0] integ_q [ORDER];
  logic signed [ACC_W-1:0] integ_d [ORDER];
  logic signed [ACC_W-1:0] comb_q  [ORDER];
  logic signed [ACC_W-1:0] comb_d  [ORDER];
  logic signed [ACC_W-1:0] dly_q   [ORDER];
  logic signed [ACC_W-1:0] dly_d   [ORDER];
  logic signed [ACC_W-1:0] src     [ORDER];
  logic signed [ACC_W-1:0] step;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] s;
  logic signed [OUT_W-1:0] xp_q, xp_d, yp_q, yp_d;
  logic signed [HW-1:0]    hpf_sum;

  always_comb begin
    step = pdm ? ACC_W'(1) : {ACC_W{1'b1}};
    // Integrators chain combinationally so a tick sees every sample up to and including its own.
    integ_d[0] = integ_q[0] + step;
    for (int k = 1; k < ORDER; k++) integ_d[k] = integ_q[k] + integ_d[k-1];

    src[0] = integ_d[ORDER-1];
    for (int k = 1; k < ORDER; k++) src[k] = comb_q[k-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_d[k] = comb_q[k];
      dly_d[k]  = dly_q[k];
      if (vld_pipe[k]) begin
        comb_d[k] = src[k] - dly_q[k];
        dly_d[k]  = src[k];
      end
    end

    shifted = comb_q[ORDER-1] >>> ctrl.shift;
    s       = OUT_W'(sat(64'(shifted), OUT_W));
    hpf_sum = HW'(s) - HW'(xp_q)
            + ((HW'($signed({1'b0, ctrl.alpha})) * HW'(yp_q)) >>> HPF_SHIFT);
    y       = ctrl.hpf_en ? OUT_W'(sat(64'(hpf_sum), OUT_W)) : s;

    xp_d = xp_q;
    yp_d = yp_q;
    if (vld_pipe[ORDER] && ctrl.hpf_en) begin
      xp_d = s;
      yp_d = y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
      xp_q <= '0;
      yp_q <= '0;
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
      xp_q <= xp_d;
      yp_q <= yp_d;
    end
  end

endmodule

// File: rtl/cic_pdm_multi.sv
// Multi-channel PDM-to-PCM decimator: shared frame counter and control sampling,
// per-channel CIC/HPF lanes, and a valid/ready output register with sticky overrun.
module cic_pdm_multi
  import cic_pdm_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int ORDER     = 3,
  parameter  int MAX_DECIM = 64,
  parameter  int OUT_W     = OUT_W_DEF,
  localparam int CNT_W     = $clog2(MAX_DECIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pdm_in,
  input  logic [CNT_W-1:0]        decim_m1,
  input  logic [2:0]              scale_shift,
  input  logic                    hpf_en,
  input  logic [7:0]              hpf_alpha,
  output logic [NUM_CH*OUT_W-1:0] pcm_out,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int ACC_W = acc_w(ORDER, CNT_W);

  logic [CNT_W-1:0] count_q, count_d, decim_q, decim_d;
  logic             tick;
  logic [ORDER-1:0] vld_pipe_q, vld_pipe_d;
  logic [ORDER:0]   vld_pipe;
  ctrl_t            ctrl_pipe_q [ORDER];
  ctrl_t            ctrl_pipe_d [ORDER];
  logic             new_set;
  logic             pcm_valid_q, pcm_valid_d, overrun_q, overrun_d;
  logic [NUM_CH-1:0][OUT_W-1:0] y_all, pcm_out_q, pcm_out_d;

  always_comb begin
    tick       = (count_q == decim_q);
    count_d    = tick ? '0 : count_q + CNT_W'(1);
    decim_d    = tick ? decim_m1 : decim_q;
    vld_pipe   = {vld_pipe_q, tick};
    vld_pipe_d = vld_pipe[ORDER-1:0];

    // Stage 0 latches the controls at tick; the rest just follow the frame down the comb pipe.
    ctrl_pipe_d[0] = tick ? ctrl_t'{shift: scale_shift, hpf_en: hpf_en, alpha: hpf_alpha}
                          : ctrl_pipe_q[0];
    for (int k = 1; k < ORDER; k++) ctrl_pipe_d[k] = ctrl_pipe_q[k-1];

    new_set     = vld_pipe[ORDER];
    pcm_out_d   = new_set ? y_all : pcm_out_q;
    pcm_valid_d = new_set | (pcm_valid_q & ~pcm_ready);
    overrun_d   = (new_set & pcm_valid_q & ~pcm_ready) | (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      // The first frame after reset runs at whatever ratio is presented during reset.
      decim_q     <= decim_m1;
      vld_pipe_q  <= '0;
      for (int k = 0; k < ORDER; k++) ctrl_pipe_q[k] <= '0;
      pcm_out_q   <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      decim_q     <= decim_d;
      vld_pipe_q  <= vld_pipe_d;
      for (int k = 0; k < ORDER; k++) ctrl_pipe_q[k] <= ctrl_pipe_d[k];
      pcm_out_q   <= pcm_out_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    cic_pdm_chan #(
      .ORDER (ORDER),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .pdm      (pdm_in[c]),
      .vld_pipe (vld_pipe),
      .ctrl     (ctrl_pipe_q[ORDER-1]),
      .y        (y_all[c])
    );
  end

  assign pcm_out   = pcm_out_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_pdm_multi.sv
// Bench for cic_pdm_multi: reference CIC as boxcar^ORDER convolution over recorded PDM history,
// plus spec-level scale/saturate/HPF arithmetic and directed handshake/decimation scenarios.
module tb_cic_pdm_multi;

  localparam int NUM_CH = 2, ORDER = 3, MAX_DECIM = 64, OUT_W = 16, CNT_W = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       pdm_in;
  logic [CNT_W-1:0]        decim_m1;
  logic [2:0]              scale_shift;
  logic                    hpf_en;
  logic [7:0]              hpf_alpha;
  logic [NUM_CH*OUT_W-1:0] pcm_out;
  logic                    pcm_valid, pcm_ready, overrun, overrun_clr;

  int checks = 0, failures = 0, cyc = 0;
  int xs [NUM_CH][8192];
  int h [256];
  int hlen;
  int last_obs [NUM_CH];

  cic_pdm_multi #(.NUM_CH(NUM_CH), .ORDER(ORDER), .MAX_DECIM(MAX_DECIM), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .decim_m1(decim_m1), .scale_shift(scale_shift),
    .hpf_en(hpf_en), .hpf_alpha(hpf_alpha), .pcm_out(pcm_out), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int obs(input int ch);
    return int'($signed(pcm_out[ch*OUT_W +: OUT_W]));
  endfunction

  // Impulse response of ORDER cascaded length-r moving sums.
  task automatic build_h(input int r);
    int tmp [256];
    int nl, acc;
    for (int n = 0; n < 256; n++) h[n] = 0;
    h[0] = 1;
    hlen = 1;
    for (int o = 0; o < ORDER; o++) begin
      nl = hlen + r - 1;
      for (int n = 0; n < nl; n++) begin
        acc = 0;
        for (int i = 0; i < r; i++)
          if (n - i >= 0 && n - i < hlen) acc += h[n-i];
        tmp[n] = acc;
      end
      for (int n = 0; n < nl; n++) h[n] = tmp[n];
      hlen = nl;
    end
  endtask

  // Decimated output j: filter response at the last sample of frame j; pre-reset history is zero.
  function automatic longint cic_model(input int ch, input int j, input int r);
    longint acc = 0;
    int t_end = j * r + r - 1;
    for (int k = 0; k < hlen; k++)
      if (t_end - k >= 0) acc += longint'(h[k]) * longint'(xs[ch][t_end-k]);
    return acc;
  endfunction

  function automatic logic pdm_bit(input int mode, input int ch, input int t);
    case (mode)
      1: return 1'b1;
      2: return 1'b0;
      3: return (t % 2 == 0);
      4: return (ch == 0);
      5: return ($urandom_range(0, 3) != 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic drive_pdm(input int mode, input int t);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pdm_in[ch] = pdm_bit(mode, ch, t);
      xs[ch][t]  = pdm_in[ch] ? 1 : -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pdm_in = '0;
    step();
    chk("rst_valid", int'(pcm_valid), 0);
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run(input int r, input int sh, input int hen, input int al,
                     input int mode, input int nfr, input int mono);
    int xp [NUM_CH];
    int yp [NUM_CH];
    int exp_v, j, s, y, o;
    longint hv;
    for (int ch = 0; ch < NUM_CH; ch++) begin xp[ch] = 0; yp[ch] = 0; end
    build_h(r);
    decim_m1 = CNT_W'(r - 1); scale_shift = 3'(sh); hpf_en = 1'(hen); hpf_alpha = 8'(al);
    pcm_ready = 1'b1; overrun_clr = 1'b0;
    do_reset();
    for (int t = 0; t < r * nfr + ORDER + 1; t++) begin
      if (t == 0) begin
        chk("rst_out0", obs(0), 0);
        chk("rst_overrun", int'(overrun), 0);
      end
      exp_v = (t >= r + ORDER && (t - r - ORDER) % r == 0) ? 1 : 0;
      chk("valid_timing", int'(pcm_valid), exp_v);
      if (exp_v == 1) begin
        j = (t - r - ORDER) / r;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          s = sat16(cic_model(ch, j, r) >>> sh);
          if (hen != 0) begin
            hv = longint'(s) - longint'(xp[ch]) + ((longint'(al) * longint'(yp[ch])) >>> 8);
            y = sat16(hv);
            xp[ch] = s;
            yp[ch] = y;
          end else y = s;
          o = obs(ch);
          chk($sformatf("data_r%0d_f%0d_ch%0d", r, j, ch), o, y);
          if (mono != 0 && j >= 5) chk("hpf_monotone", int'(o <= last_obs[ch]), 1);
          last_obs[ch] = o;
        end
      end
      drive_pdm(mode, t);
      step();
    end
    chk("no_overrun", int'(overrun), 0);
  endtask

  initial begin
    rst = 1'b1; pdm_in = '0; decim_m1 = CNT_W'(63); scale_shift = 3'd4; hpf_en = 1'b0;
    hpf_alpha = 8'd0; pcm_ready = 1'b1; overrun_clr = 1'b0;

    run(64, 4, 0, 0, 1, 5, 0);
    chk("ones_ch0", last_obs[0], 16384);
    chk("ones_ch1", last_obs[1], 16384);
    run(64, 4, 0, 0, 2, 5, 0);
    chk("zeros_ch0", last_obs[0], -16384);
    chk("zeros_ch1", last_obs[1], -16384);
    run(64, 3, 0, 0, 1, 5, 0);
    chk("sat_ch0", last_obs[0], 32767);
    run(64, 4, 0, 0, 3, 5, 0);
    chk("alt_ch0", last_obs[0], 0);
    chk("alt_ch1", last_obs[1], 0);
    run(64, 4, 0, 0, 4, 5, 0);
    chk("split_ch0", last_obs[0], 16384);
    chk("split_ch1", last_obs[1], -16384);
    run(8, 0, 0, 0, 0, 20, 0);
    run(5, 1, 1, int'($urandom_range(0, 255)), 5, 30, 0);
    run(64, 2, 0, 0, 0, 4, 0);
    run(64, 4, 1, 240, 1, 100, 1);
    chk("hpf_settle_ch0", int'(last_obs[0] < 64 && last_obs[0] > -64), 1);
    chk("hpf_settle_ch1", int'(last_obs[1] < 64 && last_obs[1] > -64), 1);

    // Overrun: consumer stalls across two arrivals, then clears, then accepts on an arrival cycle.
    decim_m1 = CNT_W'(3); scale_shift = 3'd0; hpf_en = 1'b0; pcm_ready = 1'b0; overrun_clr = 1'b0;
    build_h(4);
    do_reset();
    for (int t = 0; t < 18; t++) begin
      if (t == 6)  chk("ovr_valid_pre", int'(pcm_valid), 0);
      if (t == 7) begin
        chk("ovr_valid_first", int'(pcm_valid), 1);
        chk("ovr_flag_first", int'(overrun), 0);
        chk("ovr_data_f0", obs(0), sat16(cic_model(0, 0, 4)));
      end
      if (t == 10) chk("ovr_hold_f0", obs(1), sat16(cic_model(1, 0, 4)));
      if (t == 11) begin
        chk("ovr_valid_second", int'(pcm_valid), 1);
        chk("ovr_flag_set", int'(overrun), 1);
        chk("ovr_data_f1", obs(0), sat16(cic_model(0, 1, 4)));
      end
      if (t == 12) chk("ovr_flag_clr", int'(overrun), 0);
      if (t == 15) begin
        chk("ack_on_arrival_valid", int'(pcm_valid), 1);
        chk("ack_on_arrival_ovr", int'(overrun), 0);
        chk("ack_on_arrival_f2", obs(1), sat16(cic_model(1, 2, 4)));
      end
      if (t == 16) chk("ack_valid_drop", int'(pcm_valid), 0);
      pcm_ready   = (t >= 14);
      overrun_clr = (t == 11);
      drive_pdm(1, t);
      step();
    end
    overrun_clr = 1'b0;

    // Ratio change mid-frame: the current 64-cycle frame completes, then 32-cycle frames.
    decim_m1 = CNT_W'(63); scale_shift = 3'd4; pcm_ready = 1'b1;
    do_reset();
    for (int t = 0; t < 171; t++) begin
      chk($sformatf("decim_valid_t%0d", t), int'(pcm_valid),
          (t == 67 || t == 99 || t == 131 || t >= 163) ? 1 : 0);
      if (t == 10)  decim_m1 = CNT_W'(31);
      if (t == 140) pcm_ready = 1'b0;
      drive_pdm(0, t);
      step();
    end
    // Reset with a set pending and a partial frame: the next run sees cleared state.
    run(32, 4, 0, 0, 1, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
